// File: rtl/ntt_butterfly_pkg.sv
// Shared widths and mode encodings for the radix-2 NTT butterfly.
package ntt_butterfly_pkg;

    localparam int DATA_SIZE_ARB = 16;

    typedef enum logic {
        BF_CT = 1'b0,
        BF_GS = 1'b1
    } bf_mode_e;

endpackage

// File: rtl/ntt_butterfly_mod_add_sub.sv
// Combinational modular adder/subtractor: (x+y) mod q and (x-y) mod q.
// Both operands must already be reduced below q.
module mod_add_sub
    import ntt_butterfly_pkg::*;
#(
    parameter int W = DATA_SIZE_ARB
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    input  logic [W-1:0] q_i,
    output logic [W-1:0] sum_o,
    output logic [W-1:0] diff_o
);

    logic [W:0] sum_ext;
    logic [W:0] diff_ext;

    // One conditional correction is enough because x, y < q.
    always_comb begin
        sum_ext  = {1'b0, x_i} + {1'b0, y_i};
        diff_ext = {1'b0, x_i} - {1'b0, y_i};
        sum_o    = (sum_ext >= {1'b0, q_i}) ? W'(sum_ext - {1'b0, q_i}) : sum_ext[W-1:0];
        diff_o   = (x_i < y_i) ? W'(diff_ext + {1'b0, q_i}) : diff_ext[W-1:0];
    end

endmodule

// File: rtl/ntt_butterfly.sv
// Pipelined CT/GS radix-2 NTT butterfly wrapped around an external ModMult.
// Latency is MM_LAT+2 in both modes, so mixed-mode streams never collide.
module ntt_butterfly
    import ntt_butterfly_pkg::*;
#(
    parameter int MM_LAT = 6,
    parameter int W      = DATA_SIZE_ARB
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic         mode,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [W-1:0] W_tw,
    input  logic [W-1:0] q,
    output logic [W-1:0] mm_a,
    output logic [W-1:0] mm_b,
    input  logic [W-1:0] mm_c,
    output logic         out_valid,
    output logic [W-1:0] E,
    output logic [W-1:0] O,
    output logic         busy
);

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] s;
        logic         mode;
        logic         valid;
    } carry_t;

    logic [W-1:0] gs_sum, gs_diff, ct_sum, ct_diff;
    logic [W-1:0] mm_a_d, mm_a_q, mm_b_q;
    logic [W-1:0] e_d, e_q, o_d, o_q;
    logic         out_valid_q;
    logic         busy_d;
    carry_t       s1_d, s1_q;
    carry_t       dl_q [MM_LAT];
    carry_t       dl_out;

    mod_add_sub #(.W(W)) u_stage1 (
        .x_i    (A),
        .y_i    (B),
        .q_i    (q),
        .sum_o  (gs_sum),
        .diff_o (gs_diff)
    );

    // GS does its add/sub before the multiply; CT just forwards B.
    always_comb begin
        s1_d.a     = A;
        s1_d.s     = gs_sum;
        s1_d.mode  = mode;
        s1_d.valid = in_valid;
        mm_a_d     = (bf_mode_e'(mode) == BF_GS) ? gs_diff : B;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q   <= '0;
            mm_a_q <= '0;
            mm_b_q <= '0;
        end else begin
            s1_q   <= s1_d;
            mm_a_q <= mm_a_d;
            mm_b_q <= W_tw;
        end
    end

    // Carried operands ride alongside the ModMult pipeline so they meet mm_c.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MM_LAT; i++) begin
                dl_q[i] <= '0;
            end
        end else begin
            dl_q[0] <= s1_q;
            for (int i = 1; i < MM_LAT; i++) begin
                dl_q[i] <= dl_q[i-1];
            end
        end
    end

    assign dl_out = dl_q[MM_LAT-1];

    mod_add_sub #(.W(W)) u_stage2 (
        .x_i    (dl_out.a),
        .y_i    (mm_c),
        .q_i    (q),
        .sum_o  (ct_sum),
        .diff_o (ct_diff)
    );

    always_comb begin
        e_d = e_q;
        o_d = o_q;
        if (dl_out.valid) begin
            if (bf_mode_e'(dl_out.mode) == BF_GS) begin
                e_d = dl_out.s;
                o_d = mm_c;
            end else begin
                e_d = ct_sum;
                o_d = ct_diff;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q         <= '0;
            o_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            e_q         <= e_d;
            o_q         <= o_d;
            out_valid_q <= dl_out.valid;
        end
    end

    // Busy covers every tagged stage, including the output register.
    always_comb begin
        busy_d = s1_q.valid | out_valid_q;
        for (int i = 0; i < MM_LAT; i++) begin
            busy_d = busy_d | dl_q[i].valid;
        end
    end

    assign mm_a      = mm_a_q;
    assign mm_b      = mm_b_q;
    assign E         = e_q;
    assign O         = o_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_d;

endmodule

// File: tb/tb_ntt_butterfly.sv
// Bench for ntt_butterfly: two instances (MM_LAT=6 and MM_LAT=1) share one stimulus
// stream, each with its own ModMult model and scoreboard queue.
module tb_ntt_butterfly;
    import ntt_butterfly_pkg::*;

    localparam int W = DATA_SIZE_ARB;

    typedef struct {
        logic [W-1:0] e;
        logic [W-1:0] o;
        int           due;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         inValid = 1'b0;
    logic         modeIn = 1'b0;
    logic [W-1:0] aIn = '0;
    logic [W-1:0] bIn = '0;
    logic [W-1:0] wIn = '0;
    logic [W-1:0] qIn = 16'd7681;

    logic [W-1:0] mmA [2];
    logic [W-1:0] mmB [2];
    logic [W-1:0] mmC [2];
    logic [W-1:0] eOut [2];
    logic [W-1:0] oOut [2];
    logic         ov [2];
    logic         bsy [2];

    exp_t expQ [2][$];
    int   cycle = 0;
    int   checks = 0;
    int   errors = 0;
    int   lastCycle;

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    function automatic int latOf(input int g);
        return (g == 0) ? 8 : 3;
    endfunction

    function automatic void golden(input logic m, input longint a, input longint b,
                                   input longint w, input longint qq,
                                   output logic [W-1:0] e, output logic [W-1:0] o);
        longint p;
        if (m == BF_CT) begin
            p = (b * w) % qq;
            e = W'((a + p) % qq);
            o = W'((a - p + qq) % qq);
        end else begin
            e = W'((a + b) % qq);
            o = W'((((a - b + qq) % qq) * w) % qq);
        end
    endfunction

    task automatic checkOutput(input string tag, input longint obs, input longint expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic v, input logic m,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] w);
        exp_t item;
        @(posedge clk);
        #1;
        reset   = rst;
        inValid = v;
        modeIn  = m;
        aIn     = a;
        bIn     = b;
        wIn     = w;
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                while (expQ[g].size() > 0 && expQ[g][$].due > cycle) void'(expQ[g].pop_back());
            end else if (v) begin
                golden(m, longint'(a), longint'(b), longint'(w), longint'(qIn), item.e, item.o);
                item.due = cycle + latOf(g);
                expQ[g].push_back(item);
            end
        end
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, BF_CT, '0, '0, '0);
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            idle();
            @(negedge clk);
            if (expQ[0].size() == 0 && expQ[1].size() == 0) break;
        end
        checkOutput("drain pending", expQ[0].size() + expQ[1].size(), 0);
        idle();
    endtask

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : gLane
            localparam int ML = (g == 0) ? 6 : 1;
            logic [W-1:0] pipe [ML];
            exp_t head;

            always @(posedge clk) begin
                pipe[0] <= W'((longint'(mmA[g]) * longint'(mmB[g])) % longint'(qIn));
                for (int i = 1; i < ML; i++) pipe[i] <= pipe[i-1];
            end
            assign mmC[g] = pipe[ML-1];

            ntt_butterfly #(.MM_LAT(ML)) dut (
                .clk       (clk),
                .reset     (reset),
                .in_valid  (inValid),
                .mode      (modeIn),
                .A         (aIn),
                .B         (bIn),
                .W_tw      (wIn),
                .q         (qIn),
                .mm_a      (mmA[g]),
                .mm_b      (mmB[g]),
                .mm_c      (mmC[g]),
                .out_valid (ov[g]),
                .E         (eOut[g]),
                .O         (oOut[g]),
                .busy      (bsy[g])
            );

            always @(negedge clk) begin
                if (ov[g]) begin
                    if (expQ[g].size() == 0) begin
                        checkOutput($sformatf("lane%0d out_valid unexpected", g), ov[g], 0);
                    end else begin
                        head = expQ[g].pop_front();
                        checkOutput($sformatf("lane%0d E", g), eOut[g], head.e);
                        checkOutput($sformatf("lane%0d O", g), oOut[g], head.o);
                        checkOutput($sformatf("lane%0d out cycle", g), cycle, head.due);
                    end
                end
                if (expQ[g].size() > 0) begin
                    checkOutput($sformatf("lane%0d missed output", g), expQ[g][0].due < cycle, 0);
                end
            end
        end
    endgenerate

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // In-valid while reset is held must be ignored.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, BF_CT, 16'd5, 16'd9, 16'd2);
        idle();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("reset lane%0d out_valid", k), ov[k], 0);
            checkOutput($sformatf("reset lane%0d E", k), eOut[k], 0);
            checkOutput($sformatf("reset lane%0d O", k), oOut[k], 0);
            checkOutput($sformatf("reset lane%0d busy", k), bsy[k], 0);
            checkOutput($sformatf("reset lane%0d mm_a", k), mmA[k], 0);
            checkOutput($sformatf("reset lane%0d mm_b", k), mmB[k], 0);
        end

        applyStimulus(1'b0, 1'b1, BF_CT, 16'd100, 16'd200, 16'd3);
        drain();
        applyStimulus(1'b0, 1'b1, BF_GS, 16'd100, 16'd200, 16'd3);
        drain();
        applyStimulus(1'b0, 1'b1, BF_CT, 16'd7680, 16'd1, 16'd1);
        applyStimulus(1'b0, 1'b1, BF_GS, 16'd0, 16'd7680, 16'd1);
        drain();

        // Back-to-back stream with alternating mode.
        for (int k = 0; k < 64; k++) begin
            applyStimulus(1'b0, 1'b1, ((k % 2) == 1),
                          W'($urandom_range(0, 7680)), W'($urandom_range(0, 7680)),
                          W'($urandom_range(0, 7680)));
            @(negedge clk);
            if (k > 0) begin
                checkOutput("lane0 busy streaming", bsy[0], 1);
                checkOutput("lane1 busy streaming", bsy[1], 1);
            end
        end
        lastCycle = cycle;
        for (int c = 1; c <= 9; c++) begin
            idle();
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checkOutput($sformatf("lane%0d busy tail c%0d", k, c), bsy[k],
                            (cycle <= lastCycle + latOf(k)) ? 1 : 0);
            end
        end
        drain();

        // Bubble pattern 1,0,0,1,1,0,1.
        for (int k = 0; k < 7; k++) begin
            applyStimulus(1'b0, ((7'b1011001 >> k) & 7'd1) != 0, ((k % 3) == 0),
                          W'($urandom_range(0, 7680)), W'($urandom_range(0, 7680)),
                          W'($urandom_range(0, 7680)));
        end
        drain();

        // Reset with three transactions in flight, then an immediate new one.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, ((k % 2) == 1), W'(100 + k), W'(7000 - k), 16'd55);
        end
        applyStimulus(1'b1, 1'b1, BF_CT, 16'd5, 16'd6, 16'd7);
        applyStimulus(1'b0, 1'b1, BF_GS, 16'd1234, 16'd4321, 16'd77);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("midreset lane%0d out_valid", k), ov[k], 0);
            checkOutput($sformatf("midreset lane%0d E", k), eOut[k], 0);
            checkOutput($sformatf("midreset lane%0d O", k), oOut[k], 0);
            checkOutput($sformatf("midreset lane%0d busy", k), bsy[k], 0);
        end
        drain();

        // Different modulus, changed only while idle.
        qIn = 16'd97;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 1'b1, ((k % 2) == 0),
                          W'($urandom_range(0, 96)), W'($urandom_range(0, 96)),
                          W'($urandom_range(0, 96)));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
